// File: rtl/wd_sched.sv
// Round-robin burst scheduler: grants one stream at a time a burst of `beats` write-data beats.
// Optional per-stream grant counters on o_cnt are built when WD_SCHED_CNT_EN is defined.
module wd_sched #(
    parameter int streams       = 4,
    parameter int beats         = 8,
    parameter int streams_width = $clog2(streams),
    parameter int beats_width   = $clog2(beats)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [streams-1:0]       i_v,
    output logic [streams-1:0]       i_r,
    output logic                     o_v,
    input  logic                     o_r,
    output logic [streams_width-1:0] o_id,
    output logic [beats_width-1:0]   o_beat,
    output logic                     o_last
`ifdef WD_SCHED_CNT_EN
    ,
    output logic [streams*16-1:0]    o_cnt
`endif
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                   state, state_nxt;
    logic [streams_width-1:0] ptr;
    logic [streams_width-1:0] id;
    logic [beats_width-1:0]   beat;
    logic [streams_width-1:0] win;
    logic [streams_width-1:0] cand;
    logic                     found;
    logic                     accept;

    // First requesting stream at or above ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int j = 0; j < streams; j++) begin
            cand = streams_width'((int'(ptr) + j) % streams);
            if (!found && i_v[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        i_r       = '0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    accept    = 1'b1;
                    state_nxt = BURST;
                end
                // Gated by reset so an asserted reset silences the grant immediately.
                if (found && reset) i_r[win] = 1'b1;
            end
            BURST: begin
                if (o_r && o_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr   <= '0;
            id    <= '0;
            beat  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                id   <= win;
                ptr  <= (win == streams_width'(streams - 1)) ? '0 : win + 1'b1;
                beat <= '0;
            end else if (o_v && o_r && !o_last) begin
                // The final beat index is kept so o_beat holds its last value while idle.
                beat <= beat + 1'b1;
            end
        end
    end

    assign o_v    = (state == BURST);
    assign o_last = (state == BURST) && (beat == beats_width'(beats - 1));
    assign o_id   = id;
    assign o_beat = beat;

`ifdef WD_SCHED_CNT_EN
    logic [15:0] cnt [streams];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < streams; k++) cnt[k] <= '0;
        end else if (accept) begin
            cnt[win] <= cnt[win] + 16'd1;
        end
    end

    for (genvar g = 0; g < streams; g++) begin : g_cnt
        assign o_cnt[16*g +: 16] = cnt[g];
    end
`endif

endmodule

// File: tb/tb_wd_sched.sv
// Self-checking bench for wd_sched: directed scenarios plus a randomized run against a reference model.
module tb_wd_sched;

    localparam int S  = 4;
    localparam int B  = 8;
    localparam int SW = 2;
    localparam int BW = 3;

    logic          clk;
    logic          reset;
    logic [S-1:0]  i_v;
    logic [S-1:0]  i_r;
    logic          o_v;
    logic          o_r;
    logic [SW-1:0] o_id;
    logic [BW-1:0] o_beat;
    logic          o_last;
`ifdef WD_SCHED_CNT_EN
    logic [S*16-1:0] o_cnt;
`endif

    int tests_run;
    int tests_failed;

    wd_sched #(.streams(S), .beats(B)) dut (
        .clk(clk), .reset(reset), .i_v(i_v), .i_r(i_r), .o_v(o_v), .o_r(o_r),
        .o_id(o_id), .o_beat(o_beat), .o_last(o_last)
`ifdef WD_SCHED_CNT_EN
        , .o_cnt(o_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        i_v   = '0;
        o_r   = 1'b1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        i_v   = 4'b1111;
        o_r   = 1'b1;
        reset = 1'b0;
        #3;
        tests_run++;
        if (o_v !== 1'b0 || i_r !== 4'b0000 || o_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: o_v=%b i_r=%b o_last=%b, required 0/0000/0", o_v, i_r, o_last);
        end
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (o_id !== 2'd0 || o_beat !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_state: o_id=%0d o_beat=%0d, required 0/0", o_id, o_beat);
        end
        i_v   = '0;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_single();
        apply_reset();
        i_v = 4'b0100;
        #1;
        tests_run++;
        if (i_r !== 4'b0100) begin
            tests_failed++;
            $display("FAIL single_grant: i_r=%b, required 0100", i_r);
        end
        next_cycle();
        i_v = '0;
        for (int b = 0; b < B; b++) begin
            #1;
            tests_run++;
            if (o_v !== 1'b1 || o_id !== 2'd2 || int'(o_beat) !== b || o_last !== (b == B - 1) || i_r !== 4'b0) begin
                tests_failed++;
                $display("FAIL single_beat%0d: o_v=%b o_id=%0d o_beat=%0d o_last=%b i_r=%b, required 1/2/%0d/%0b/0000",
                         b, o_v, o_id, o_beat, o_last, i_r, b, (b == B - 1));
            end
            next_cycle();
        end
        tests_run++;
        if (o_v !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_gap: o_v=%b, required 0", o_v);
        end
    endtask

    task automatic test_all_requests();
        int order [5] = '{0, 1, 2, 3, 0};
        apply_reset();
        i_v = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            #1;
            tests_run++;
            if (o_v !== 1'b0 || i_r !== 4'(1 << order[g])) begin
                tests_failed++;
                $display("FAIL all_grant%0d: o_v=%b i_r=%b, required 0/%b", g, o_v, i_r, 4'(1 << order[g]));
            end
            next_cycle();
            for (int b = 0; b < B; b++) begin
                tests_run++;
                if (o_v !== 1'b1 || int'(o_id) !== order[g] || int'(o_beat) !== b) begin
                    tests_failed++;
                    $display("FAIL all_burst%0d_beat%0d: o_v=%b o_id=%0d o_beat=%0d, required 1/%0d/%0d",
                             g, b, o_v, o_id, o_beat, order[g], b);
                end
                next_cycle();
            end
        end
        i_v = '0;
        next_cycle();
    endtask

    task automatic test_back_pressure();
        int cycles;
        int accepted;
        int stall;
        apply_reset();
        i_v = 4'b0001;
        next_cycle();
        i_v      = '0;
        cycles   = 0;
        accepted = 0;
        stall    = 0;
        while (accepted < B && cycles < 30) begin
            if (accepted == 3 && stall < 3) begin
                o_r = 1'b0;
                stall++;
            end else begin
                o_r = 1'b1;
            end
            #1;
            tests_run++;
            if (o_v !== 1'b1 || int'(o_beat) !== accepted) begin
                tests_failed++;
                $display("FAIL bp_cycle%0d: o_v=%b o_beat=%0d, required 1/%0d", cycles, o_v, o_beat, accepted);
            end
            if (o_r) accepted++;
            next_cycle();
            cycles++;
        end
        o_r = 1'b1;
        tests_run++;
        if (cycles !== B + 3 || o_v !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_length: cycles=%0d o_v=%b, required %0d/0", cycles, o_v, B + 3);
        end
    endtask

    task automatic test_ptr_wrap();
        apply_reset();
        i_v = 4'b1000;
        #1;
        tests_run++;
        if (i_r !== 4'b1000) begin
            tests_failed++;
            $display("FAIL wrap_first: i_r=%b, required 1000", i_r);
        end
        next_cycle();
        i_v = 4'b1001;
        repeat (B) next_cycle();
        tests_run++;
        if (o_v !== 1'b0 || i_r !== 4'b0001) begin
            tests_failed++;
            $display("FAIL wrap_second: o_v=%b i_r=%b, required 0/0001", o_v, i_r);
        end
        next_cycle();
        i_v = '0;
        tests_run++;
        if (o_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL wrap_id: o_id=%0d, required 0", o_id);
        end
        repeat (B) next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        i_v = 4'b1000;
        next_cycle();
        i_v = '0;
        repeat (5) next_cycle();
        tests_run++;
        if (o_v !== 1'b1 || o_beat !== 3'd5) begin
            tests_failed++;
            $display("FAIL rst_mid_pre: o_v=%b o_beat=%0d, required 1/5", o_v, o_beat);
        end
        i_v   = 4'b1000;
        reset = 1'b0;
        #1;
        tests_run++;
        if (o_v !== 1'b0 || i_r !== 4'b0000 || o_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_async: o_v=%b i_r=%b o_last=%b, required 0/0000/0", o_v, i_r, o_last);
        end
        next_cycle();
        reset = 1'b1;
        #1;
        tests_run++;
        if (i_r !== 4'b1000 || o_v !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_regrant: i_r=%b o_v=%b, required 1000/0", i_r, o_v);
        end
        next_cycle();
        i_v = '0;
        tests_run++;
        if (o_v !== 1'b1 || o_id !== 2'd3 || o_beat !== 3'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_restart: o_v=%b o_id=%0d o_beat=%0d, required 1/3/0", o_v, o_id, o_beat);
        end
        repeat (B) next_cycle();
    endtask

`ifdef WD_SCHED_CNT_EN
    task automatic test_counters();
        apply_reset();
        for (int n = 0; n < 3; n++) begin
            i_v = 4'b0010;
            next_cycle();
            i_v = '0;
            repeat (B) next_cycle();
        end
        tests_run++;
        if (o_cnt !== {16'd0, 16'd0, 16'd3, 16'd0}) begin
            tests_failed++;
            $display("FAIL cnt_three: o_cnt=%h, required %h", o_cnt, {16'd0, 16'd0, 16'd3, 16'd0});
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (o_cnt !== '0) begin
            tests_failed++;
            $display("FAIL cnt_reset: o_cnt=%h, required 0", o_cnt);
        end
        next_cycle();
        reset = 1'b1;
        #1;
    endtask
`endif

    // Transaction-level model: a burst owner plus a count of beats still owed.
    task automatic test_random();
        logic [S-1:0] pend;
        bit           busy;
        int           rr;
        int           owner;
        int           owed;
        int           exp_k;
        int           grants [S];
        logic [S-1:0] exp_ir;
        apply_reset();
        pend  = '0;
        busy  = 0;
        rr    = 0;
        owner = 0;
        owed  = 0;
        for (int k = 0; k < S; k++) grants[k] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < S; k++) begin
                if (!pend[k] && $urandom_range(0, 3) == 0) pend[k] = 1'b1;
                else if (pend[k] && $urandom_range(0, 15) == 0) pend[k] = 1'b0;
            end
            i_v = pend;
            o_r = ($urandom_range(0, 3) != 0);
            exp_k  = -1;
            exp_ir = '0;
            if (!busy) begin
                for (int j = 0; j < S; j++) begin
                    if (exp_k < 0 && pend[(rr + j) % S]) exp_k = (rr + j) % S;
                end
                if (exp_k >= 0) exp_ir[exp_k] = 1'b1;
            end
            #1;
            tests_run++;
            if (i_r !== exp_ir || o_v !== busy) begin
                tests_failed++;
                $display("FAIL rand_ctl_c%0d: i_r=%b o_v=%b, required %b/%b", c, i_r, o_v, exp_ir, busy);
            end
            tests_run++;
            if (int'(o_id) !== owner ||
                (busy && (int'(o_beat) !== B - owed || o_last !== (owed == 1)))) begin
                tests_failed++;
                $display("FAIL rand_beat_c%0d: o_id=%0d o_beat=%0d o_last=%b, required %0d/%0d/%0b",
                         c, o_id, o_beat, o_last, owner, B - owed, (owed == 1));
            end
            next_cycle();
            if (!busy && exp_k >= 0) begin
                busy  = 1;
                owner = exp_k;
                owed  = B;
                rr    = (exp_k + 1) % S;
                pend[exp_k] = 1'b0;
                grants[exp_k]++;
            end else if (busy && o_r) begin
                owed--;
                if (owed == 0) busy = 0;
            end
        end
`ifdef WD_SCHED_CNT_EN
        for (int k = 0; k < S; k++) begin
            tests_run++;
            if (int'(o_cnt[16*k +: 16]) !== grants[k]) begin
                tests_failed++;
                $display("FAIL rand_cnt%0d: o_cnt=%0d, required %0d", k, o_cnt[16*k +: 16], grants[k]);
            end
        end
`endif
        i_v = '0;
        o_r = 1'b1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        i_v   = '0;
        o_r   = 1'b1;
        reset = 1'b1;
        #2;
        test_reset();
        test_single();
        test_all_requests();
        test_back_pressure();
        test_ptr_wrap();
        test_reset_mid_burst();
`ifdef WD_SCHED_CNT_EN
        test_counters();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
